// File: rtl/ysyx_24110006_sys_ctrl_if.sv
// Pipeline handshake plus CSR-file request/response bundle for the system-instruction sequencer.
// master is the sequencer's view, slave is the pipeline/CSR-file side.
interface ysyx_24110006_sys_ctrl_if;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [1:0]  i_sys;
  logic [2:0]  i_funct3;
  logic [11:0] i_csr_addr;
  logic [4:0]  i_rs1_idx;
  logic [31:0] i_rs1_val;
  logic [31:0] i_pc;
  logic [1:0]  o_csr_t;
  logic [11:0] o_csr_r;
  logic [11:0] o_csr_w;
  logic [31:0] o_csr_wdata;
  logic [3:0]  o_csr_mcause;
  logic        o_csr_exception;
  logic        o_csr_mret;
  logic [31:0] o_csr_pc;
  logic        o_csr_valid;
  logic [31:0] i_csr_rdata;
  logic [31:0] i_csr_upc;
  logic        o_out_valid;
  logic        i_out_ready;
  logic        o_rd_we;
  logic [31:0] o_rd_data;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_illegal;

  modport master (
    input  i_in_valid, i_sys, i_funct3, i_csr_addr, i_rs1_idx, i_rs1_val, i_pc,
    input  i_csr_rdata, i_csr_upc, i_out_ready,
    output o_in_ready, o_csr_t, o_csr_r, o_csr_w, o_csr_wdata, o_csr_mcause,
    output o_csr_exception, o_csr_mret, o_csr_pc, o_csr_valid,
    output o_out_valid, o_rd_we, o_rd_data, o_redirect, o_redirect_pc, o_illegal
  );

  modport slave (
    output i_in_valid, i_sys, i_funct3, i_csr_addr, i_rs1_idx, i_rs1_val, i_pc,
    output i_csr_rdata, i_csr_upc, i_out_ready,
    input  o_in_ready, o_csr_t, o_csr_r, o_csr_w, o_csr_wdata, o_csr_mcause,
    input  o_csr_exception, o_csr_mret, o_csr_pc, o_csr_valid,
    input  o_out_valid, o_rd_we, o_rd_data, o_redirect, o_redirect_pc, o_illegal
  );
endinterface

// File: rtl/ysyx_24110006_sys_ctrl.sv
// CSR / ECALL / MRET sequencer: runs one system instruction as a short multi-cycle
// sequence against the CSR file and returns writeback and PC-redirect results.
module ysyx_24110006_sys_ctrl (
  input  logic                            i_clock,
  input  logic                            i_reset,
  ysyx_24110006_sys_ctrl_if.master        bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] TRAP  = 3'd3;
  localparam logic [2:0] RET   = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]  state_reg, state_next;
  logic [2:0]  funct3_reg;
  logic [11:0] addr_reg;
  logic [4:0]  rs1_idx_reg;
  logic [31:0] rs1_val_reg;
  logic [31:0] pc_reg;
  logic [31:0] old_reg;
  logic        rd_we_reg;
  logic [31:0] rd_data_reg;
  logic        redirect_reg;
  logic [31:0] redirect_pc_reg;
  logic        illegal_reg;

  logic [31:0] operand;
  logic [31:0] new_val;
  logic        wr_en;
  logic        write_strobe;
  logic        trap_strobe;

  // funct3[2] selects the zimm forms; set/clear with x0/zimm=0 must not touch the CSR.
  always_comb begin
    operand = funct3_reg[2] ? {27'b0, rs1_idx_reg} : rs1_val_reg;
    case (funct3_reg[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_reg | operand;
      2'b11:   new_val = old_reg & ~operand;
      default: new_val = old_reg;
    endcase
    wr_en = (funct3_reg[1:0] == 2'b01) |
            ((funct3_reg[1:0] != 2'b00) & (rs1_idx_reg != 5'd0));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.i_in_valid) begin
          case (bus.i_sys)
            2'b00:   state_next = READ;
            2'b01:   state_next = TRAP;
            2'b10:   state_next = RET;
            default: state_next = RESP;
          endcase
        end
      end
      READ:             state_next = WRITE;
      WRITE, TRAP, RET: state_next = RESP;
      RESP:             if (bus.i_out_ready) state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg       <= IDLE;
      funct3_reg      <= 3'd0;
      addr_reg        <= 12'd0;
      rs1_idx_reg     <= 5'd0;
      rs1_val_reg     <= 32'd0;
      pc_reg          <= 32'd0;
      old_reg         <= 32'd0;
      rd_we_reg       <= 1'b0;
      rd_data_reg     <= 32'd0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= 32'd0;
      illegal_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.i_in_valid) begin
            funct3_reg      <= bus.i_funct3;
            addr_reg        <= bus.i_csr_addr;
            rs1_idx_reg     <= bus.i_rs1_idx;
            rs1_val_reg     <= bus.i_rs1_val;
            pc_reg          <= bus.i_pc;
            rd_we_reg       <= 1'b0;
            rd_data_reg     <= 32'd0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= 32'd0;
            illegal_reg     <= (bus.i_sys == 2'b11);
          end
        end
        READ: old_reg <= bus.i_csr_rdata;
        WRITE: begin
          rd_data_reg <= old_reg;
          rd_we_reg   <= 1'b1;
        end
        // i_csr_upc is mtvec in TRAP and mepc in RET, sampled before the CSR update lands.
        TRAP, RET: begin
          redirect_pc_reg <= bus.i_csr_upc;
          redirect_reg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign write_strobe = (state_reg == WRITE) & wr_en;
  assign trap_strobe  = (state_reg == TRAP);

  assign bus.o_in_ready      = (state_reg == IDLE);
  assign bus.o_csr_t         = trap_strobe ? 2'b11 : (write_strobe ? 2'b01 : 2'b00);
  assign bus.o_csr_r         = addr_reg;
  assign bus.o_csr_w         = addr_reg;
  assign bus.o_csr_wdata     = write_strobe ? new_val : 32'd0;
  assign bus.o_csr_mcause    = trap_strobe ? 4'hb : 4'h0;
  assign bus.o_csr_exception = trap_strobe;
  assign bus.o_csr_mret      = (state_reg == RET);
  assign bus.o_csr_pc        = pc_reg;
  assign bus.o_csr_valid     = write_strobe | trap_strobe;
  assign bus.o_out_valid     = (state_reg == RESP);
  assign bus.o_rd_we         = rd_we_reg;
  assign bus.o_rd_data       = rd_data_reg;
  assign bus.o_redirect      = redirect_reg;
  assign bus.o_redirect_pc   = redirect_pc_reg;
  assign bus.o_illegal       = illegal_reg;
endmodule

// File: tb/tb_ysyx_24110006_sys_ctrl.sv
// Bench for the system-instruction sequencer: behavioural CSR file on the slave side,
// plus a per-instruction reference model of the architectural result.
module tb_ysyx_24110006_sys_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_24110006_sys_ctrl_if bus();
  ysyx_24110006_sys_ctrl dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Environment CSR file: combinational read, commit on the strobe edge.
  logic [31:0] f_mstatus = 32'd0;
  logic [31:0] f_mtvec   = 32'd0;
  logic [31:0] f_mepc    = 32'd0;
  logic [31:0] f_mcause  = 32'd0;

  always_comb begin
    case (bus.o_csr_r)
      12'h300: bus.i_csr_rdata = f_mstatus;
      12'h305: bus.i_csr_rdata = f_mtvec;
      12'h341: bus.i_csr_rdata = f_mepc;
      12'h342: bus.i_csr_rdata = f_mcause;
      12'hf11: bus.i_csr_rdata = 32'h79737978;
      default: bus.i_csr_rdata = 32'd0;
    endcase
    bus.i_csr_upc = bus.o_csr_mret ? f_mepc : f_mtvec;
  end

  always @(posedge clk) begin
    if (bus.o_csr_valid) begin
      if (bus.o_csr_t == 2'b01) begin
        case (bus.o_csr_w)
          12'h300: f_mstatus <= bus.o_csr_wdata;
          12'h305: f_mtvec   <= bus.o_csr_wdata;
          12'h341: f_mepc    <= bus.o_csr_wdata;
          12'h342: f_mcause  <= bus.o_csr_wdata;
          default: ;
        endcase
      end else if (bus.o_csr_t == 2'b11) begin
        f_mepc   <= bus.o_csr_pc;
        f_mcause <= {28'd0, bus.o_csr_mcause};
      end
    end
  end

  function automatic logic [31:0] env_rd(input logic [11:0] a);
    case (a)
      12'h300: return f_mstatus;
      12'h305: return f_mtvec;
      12'h341: return f_mepc;
      12'h342: return f_mcause;
      12'hf11: return 32'h79737978;
      default: return 32'd0;
    endcase
  endfunction

  // Reference architectural CSR state.
  logic [31:0] r_mstatus = 32'd0, r_mtvec = 32'd0, r_mepc = 32'd0, r_mcause = 32'd0;

  function automatic logic [31:0] ref_rd(input logic [11:0] a);
    case (a)
      12'h300: return r_mstatus;
      12'h305: return r_mtvec;
      12'h341: return r_mepc;
      12'h342: return r_mcause;
      12'hf11: return 32'h79737978;
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_wr(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: r_mstatus = v;
      12'h305: r_mtvec   = v;
      12'h341: r_mepc    = v;
      12'h342: r_mcause  = v;
      default: ;
    endcase
  endtask

  task automatic scramble_inputs();
    bus.i_in_valid = 1'($urandom_range(0, 1));
    bus.i_sys      = 2'($urandom);
    bus.i_funct3   = 3'($urandom);
    bus.i_csr_addr = 12'($urandom);
    bus.i_rs1_idx  = 5'($urandom);
    bus.i_rs1_val  = $urandom;
    bus.i_pc       = $urandom;
  endtask

  task automatic do_instr(input logic [1:0] sys, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [4:0] idx, input logic [31:0] val, input logic [31:0] pc,
                          input int stall);
    logic [31:0] e_old, e_opnd, e_new, e_rd, e_rpc;
    logic        e_we, e_rdwe, e_redir, e_ill;
    int          e_lat, e_nvalid, e_nexc, e_nmret;
    int          lat, nvalid, nexc, nmret;
    logic [31:0] s_wdata, s_pc;
    logic [11:0] s_waddr;
    logic [3:0]  s_mcause;
    logic [1:0]  s_t, s_mret_t;

    e_old = 0; e_opnd = 0; e_new = 0; e_rd = 0; e_rpc = 0; e_we = 0;
    e_rdwe = 0; e_redir = 0; e_ill = 0; e_nvalid = 0; e_nexc = 0; e_nmret = 0; e_lat = 1;
    case (sys)
      2'b00: begin
        e_lat  = 3;
        e_old  = ref_rd(addr);
        e_opnd = f3[2] ? {27'd0, idx} : val;
        case (f3[1:0])
          2'b01:   e_new = e_opnd;
          2'b10:   e_new = e_old | e_opnd;
          default: e_new = e_old & ~e_opnd;
        endcase
        e_we     = (f3[1:0] == 2'b01) || (idx != 5'd0);
        e_nvalid = e_we ? 1 : 0;
        e_rdwe   = 1'b1;
        e_rd     = e_old;
        if (e_we) ref_wr(addr, e_new);
      end
      2'b01: begin
        e_lat = 2; e_redir = 1'b1; e_rpc = r_mtvec; e_nvalid = 1; e_nexc = 1;
        r_mepc = pc; r_mcause = 32'd11;
      end
      2'b10: begin
        e_lat = 2; e_redir = 1'b1; e_rpc = r_mepc; e_nmret = 1;
      end
      default: e_ill = 1'b1;
    endcase

    @(negedge clk);
    check("in_ready_idle", bus.o_in_ready, 1'b1);
    bus.i_in_valid = 1'b1; bus.i_sys = sys; bus.i_funct3 = f3; bus.i_csr_addr = addr;
    bus.i_rs1_idx = idx; bus.i_rs1_val = val; bus.i_pc = pc; bus.i_out_ready = 1'b0;

    lat = 0; nvalid = 0; nexc = 0; nmret = 0;
    s_wdata = 0; s_pc = 0; s_waddr = 0; s_mcause = 0; s_t = 0; s_mret_t = 2'b11;
    do begin
      @(negedge clk);
      lat++;
      scramble_inputs();
      if (bus.o_csr_valid) begin
        nvalid++; s_wdata = bus.o_csr_wdata; s_waddr = bus.o_csr_w; s_t = bus.o_csr_t;
        s_pc = bus.o_csr_pc; s_mcause = bus.o_csr_mcause;
      end
      if (bus.o_csr_exception) nexc++;
      if (bus.o_csr_mret) begin nmret++; s_mret_t = bus.o_csr_t; end
    end while (!bus.o_out_valid && lat < 10);

    check("latency", lat, e_lat);
    check("resp_in_ready", bus.o_in_ready, 1'b0);
    check("rd_we", bus.o_rd_we, e_rdwe);
    check("redirect", bus.o_redirect, e_redir);
    check("illegal", bus.o_illegal, e_ill);
    check("csr_valid_count", nvalid, e_nvalid);
    check("exception_count", nexc, e_nexc);
    check("mret_count", nmret, e_nmret);
    if (e_rdwe) check("rd_data", bus.o_rd_data, e_rd);
    if (e_redir) check("redirect_pc", bus.o_redirect_pc, e_rpc);
    if (e_we) begin
      check("csr_wdata", s_wdata, e_new);
      check("csr_w", s_waddr, addr);
      check("csr_t_write", s_t, 2'b01);
    end
    if (e_nexc != 0) begin
      check("csr_t_ecall", s_t, 2'b11);
      check("csr_pc", s_pc, pc);
      check("mcause", s_mcause, 4'hb);
    end
    if (e_nmret != 0) check("csr_t_mret", s_mret_t, 2'b00);

    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      scramble_inputs();
      check("hold_out_valid", bus.o_out_valid, 1'b1);
      check("hold_in_ready", bus.o_in_ready, 1'b0);
      check("hold_csr_valid", bus.o_csr_valid, 1'b0);
      if (e_rdwe) check("hold_rd_data", bus.o_rd_data, e_rd);
      if (e_redir) check("hold_redirect_pc", bus.o_redirect_pc, e_rpc);
    end
    bus.i_out_ready = 1'b1;
    @(negedge clk);
    bus.i_out_ready = 1'b0;
    bus.i_in_valid  = 1'b0;
    check("post_out_valid", bus.o_out_valid, 1'b0);
    check("post_in_ready", bus.o_in_ready, 1'b1);
    if (sys == 2'b00) check("csr_file", env_rd(addr), ref_rd(addr));
    if (sys == 2'b01) check("mepc_file", f_mepc, r_mepc);
    $display("instr sys=%0d f3=%0d addr=%h idx=%0d val=%h pc=%h stall=%0d -> rd_we=%0d rd=%h redir=%0d rpc=%h",
             sys, f3, addr, idx, val, pc, stall, bus.o_rd_we, bus.o_rd_data,
             bus.o_redirect, bus.o_redirect_pc);
  endtask

  logic [11:0] addr_tab [6];
  logic [2:0]  f3_tab [6];

  initial begin
    addr_tab[0] = 12'h300; addr_tab[1] = 12'h305; addr_tab[2] = 12'h341;
    addr_tab[3] = 12'h342; addr_tab[4] = 12'hf11; addr_tab[5] = 12'h7c0;
    f3_tab[0] = 3'b001; f3_tab[1] = 3'b010; f3_tab[2] = 3'b011;
    f3_tab[3] = 3'b101; f3_tab[4] = 3'b110; f3_tab[5] = 3'b111;

    rst_n = 1'b0;
    bus.i_in_valid = 0; bus.i_sys = 0; bus.i_funct3 = 0; bus.i_csr_addr = 0;
    bus.i_rs1_idx = 0; bus.i_rs1_val = 0; bus.i_pc = 0; bus.i_out_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.o_in_ready, 1'b1);
    check("rst_out_valid", bus.o_out_valid, 1'b0);
    check("rst_csr_valid", bus.o_csr_valid, 1'b0);
    check("rst_csr_t", bus.o_csr_t, 2'b00);
    check("rst_csr_r", bus.o_csr_r, 12'd0);
    check("rst_rd_data", bus.o_rd_data, 32'd0);
    check("rst_redirect_pc", bus.o_redirect_pc, 32'd0);
    check("rst_illegal", bus.o_illegal, 1'b0);
    rst_n = 1'b1;

    do_instr(2'b00, 3'b001, 12'h305, 5'd1, 32'h80000100, 32'h80000000, 0);
    do_instr(2'b00, 3'b010, 12'h305, 5'd0, 32'hffffffff, 32'h80000004, 0);
    do_instr(2'b00, 3'b010, 12'hf11, 5'd0, 32'h0, 32'h80000008, 1);
    do_instr(2'b00, 3'b001, 12'h300, 5'd2, 32'h00001888, 32'h8000000c, 0);
    do_instr(2'b00, 3'b011, 12'h300, 5'd3, 32'h00001808, 32'h8000000c, 0);
    do_instr(2'b00, 3'b110, 12'h300, 5'd5, 32'hdeadbeef, 32'h8000000c, 0);
    do_instr(2'b01, 3'b000, 12'h000, 5'd0, 32'h0, 32'h80000010, 0);
    do_instr(2'b10, 3'b000, 12'h302, 5'd0, 32'h0, 32'h80000100, 0);
    do_instr(2'b11, 3'b000, 12'h000, 5'd0, 32'h0, 32'h80000014, 0);
    do_instr(2'b00, 3'b001, 12'h341, 5'd4, 32'h12345678, 32'h80000018, 5);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] s;
      int r;
      r = $urandom_range(0, 9);
      s = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_instr(s, f3_tab[$urandom_range(0, 5)], addr_tab[$urandom_range(0, 5)],
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
               {$urandom_range(0, 32'h3fffffff), 2'b00}, $urandom_range(0, 3));
    end

    // Reset in the WRITE cycle of a CSRRW to mtvec must cancel the write.
    @(negedge clk);
    bus.i_in_valid = 1'b1; bus.i_sys = 2'b00; bus.i_funct3 = 3'b001;
    bus.i_csr_addr = 12'h305; bus.i_rs1_idx = 5'd7; bus.i_rs1_val = 32'h0badf00d;
    bus.i_pc = 32'h80000200;
    @(negedge clk);
    bus.i_in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_csr_valid", bus.o_csr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_csr_valid", bus.o_csr_valid, 1'b0);
    check("reset_csr_t", bus.o_csr_t, 2'b00);
    check("reset_csr_wdata", bus.o_csr_wdata, 32'd0);
    check("reset_csr_w", bus.o_csr_w, 12'd0);
    check("reset_csr_pc", bus.o_csr_pc, 32'd0);
    check("reset_exception", bus.o_csr_exception, 1'b0);
    check("reset_mcause", bus.o_csr_mcause, 4'd0);
    check("reset_out_valid", bus.o_out_valid, 1'b0);
    check("reset_rd_we", bus.o_rd_we, 1'b0);
    check("reset_rd_data", bus.o_rd_data, 32'd0);
    check("reset_redirect", bus.o_redirect, 1'b0);
    check("reset_in_ready", bus.o_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_mtvec_kept", f_mtvec, r_mtvec);
    check("release_in_ready", bus.o_in_ready, 1'b1);
    do_instr(2'b00, 3'b010, 12'h305, 5'd0, 32'h0, 32'h80000204, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_24110006_sys_ctrl.md
# ysyx_24110006_sys_ctrl

System-instruction sequencer in the EXU and the initiator side of the CSR-file interface. Takes one decoded CSR/ECALL/MRET instruction at a time over a valid/ready handshake and performs the CSR read, read-modify-write, trap entry or trap return as a short multi-cycle sequence. Returns the rd writeback value and any PC redirect to the pipeline over a second valid/ready handshake. Drives the CSR file's `csr_t`/`csr_r`/`csr_w`/`wdata`/`mcause`/`exception`/`mret`/`pc`/`valid` inputs and consumes its `rdata`/`upc` outputs.

## Interface
- No parameters.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_in_valid  in  1  instruction offered.
- o_in_ready  out  1  high only in IDLE.
- i_sys  in  2  00 CSR op, 01 ECALL, 10 MRET, 11 unsupported.
- i_funct3  in  3  CSR op select: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- i_csr_addr  in  12  CSR address.
- i_rs1_idx  in  5  rs1 index; this is the zimm value for the immediate forms.
- i_rs1_val  in  32  rs1 value.
- i_pc  in  32  instruction PC.
- o_csr_t  out  2  00 read/MRET, 01 write, 11 ECALL.
- o_csr_r, o_csr_w  out  12  latched CSR address.
- o_csr_wdata  out  32  new CSR value.
- o_csr_mcause  out  4  4'hb on ECALL, else 0.
- o_csr_exception  out  1  trap-entry strobe.
- o_csr_mret  out  1  trap-return strobe.
- o_csr_pc  out  32  latched PC.
- o_csr_valid  out  1  CSR update strobe, one cycle.
- i_csr_rdata  in  32  combinational read data.
- i_csr_upc  in  32  combinational mtvec/mepc.
- o_out_valid  out  1  result available.
- i_out_ready  in  1  result consumed.
- o_rd_we, o_rd_data  out  1/32  writeback.
- o_redirect, o_redirect_pc  out  1/32  PC redirect.
- o_illegal  out  1  unsupported i_sys.

## Operation
- States: IDLE, READ, WRITE, TRAP, RET, RESP. Accept occurs when `i_in_valid & o_in_ready`; all inputs are latched at that edge.
- Transitions out of IDLE:
  - CSR op goes to READ.
  - i_sys=01 goes to TRAP.
  - i_sys=10 goes to RET.
  - i_sys=11 goes to RESP with o_illegal=1, o_rd_we=0, o_redirect=0.
- READ:
  - o_csr_r = latched address.
  - Capture i_csr_rdata as `old`.
  - Next state WRITE.
- WRITE:
  - Operand is `{27'b0, rs1_idx}` when funct3[2]=1, else rs1_val.
  - New value: RW gives operand; RS gives old|operand; RC gives old&~operand.
  - Write enable: RW/RWI always; set/clear forms only when rs1_idx≠0.
  - If enabled, o_csr_t=01, o_csr_valid=1, o_csr_wdata=new. Otherwise o_csr_valid=0.
  - Next state RESP with rd_data=old, rd_we=1, redirect=0.
- TRAP:
  - o_csr_exception=1, o_csr_t=11, o_csr_mcause=4'hb, o_csr_pc=pc, o_csr_valid=1.
  - Capture i_csr_upc (mtvec) into redirect_pc; redirect=1, rd_we=0.
- RET:
  - o_csr_mret=1, o_csr_t=00, o_csr_valid=0.
  - Capture i_csr_upc (mepc) into redirect_pc; redirect=1.
- RESP:
  - o_out_valid=1; outputs are held stable until i_out_ready.
  - On handshake, go to IDLE.
- CSR-side strobes (o_csr_valid, o_csr_exception, o_csr_mret) are decoded from state and are 0 outside their state.
- Unimplemented CSR addresses are passed through unchanged; their value is whatever the CSR file returns.

## Timing
- Reset:
  - State IDLE; o_in_ready=1.
  - Every other output 0, including o_csr_t=00, addresses 0 and data 0.
  - Reset asserted mid-sequence drops all strobes immediately, so no CSR write or trap occurs at the next edge. Latched data is cleared.
- Latency from accept edge to o_out_valid:
  - CSR op: 3 cycles.
  - ECALL/MRET: 2 cycles.
  - Unsupported: 1 cycle.
- Throughput: one instruction in flight; the next accept is no earlier than the cycle after the RESP handshake.
- o_in_ready=0 in every non-IDLE state; i_in_valid is ignored there.
- i_out_ready high in the first RESP cycle: IDLE on the next edge.
- CSR file contract: writes commit at the edge ending WRITE/TRAP; i_csr_upc is sampled at that same edge, before the update.

## Test plan
- CSRRW 0x305, rs1_val=0x80000100, then CSRRS 0x305 with rs1_idx=0 -> second op rd_data=0x80000100, o_csr_valid never high during the second op; CSRRS 0xf11 with rs1_idx=0 -> rd_data=0x79737978.
- CSRRW 0x300 with 0x1888, then CSRRC 0x300 with 0x1808 -> rd_data=0x1888, o_csr_wdata=0x80 with a one-cycle o_csr_valid; CSRRSI 0x300 zimm=5 -> wdata=0x85.
- ECALL at pc=0x80000010 with mtvec=0x80000100 -> one-cycle o_csr_exception with mcause=4'hb and o_csr_pc=0x80000010; response redirect=1, redirect_pc=0x80000100, rd_we=0.
- MRET following that ECALL -> one-cycle o_csr_mret, o_csr_valid=0, redirect_pc=0x80000010.
- i_out_ready held low 5 cycles in RESP, with a new instruction offered -> o_out_valid and data stable, o_in_ready=0, new instruction accepted only after the handshake.
- i_reset low during WRITE of CSRRW 0x305 -> o_csr_valid drops combinationally, mtvec unchanged, all outputs 0, o_in_ready=1 after release.
